reg_native_arbiter: RTL

//  Shares one downstream reg_native_if (e.g. the root regdisp upstream port) among NUM_MST masters
//  (APB bridge, JTAG/debug master, ...). Round-robin arbitration, one transaction in flight,
//  per-master one-entry request capture, response routing back to the granted master,
//  and ack timeout with downstream abort through soft_rst.

---
 rtl/reg_native_arb_pkg.sv | 20 ++
 rtl/reg_native_arbiter_if.sv | 27 ++
 rtl/rr_arbiter.sv | 31 +++
 rtl/reg_native_arbiter.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/reg_native_arb_pkg.sv
// Shared types for the reg_native master arbiter.
package reg_native_arb_pkg;

  // Widest address/data the captured request slots can hold.
  localparam int unsigned REQ_ADDR_W = 48;
  localparam int unsigned REQ_DATA_W = 32;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  typedef struct packed {
    logic [REQ_ADDR_W-1:0] addr;
    logic                  wr_en;
    logic                  rd_en;
    logic [REQ_DATA_W-1:0] wr_data;
  } req_t;

endpackage

// File: rtl/reg_native_arbiter_if.sv
// Single reg_native request/response bus between one master and one slave.
interface reg_native_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 48,
  parameter int unsigned DATA_WIDTH = 32
) ();

  logic                  req_vld;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  wr_en;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  soft_rst;
  logic                  ack_vld;
  logic                  err;
  logic [DATA_WIDTH-1:0] rd_data;

  modport master (
    output req_vld, addr, wr_en, rd_en, wr_data, soft_rst,
    input  ack_vld, err, rd_data
  );

  modport slave (
    input  req_vld, addr, wr_en, rd_en, wr_data, soft_rst,
    output ack_vld, err, rd_data
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set request at or after ptr, wrapping to 0.
module rr_arbiter #(
  parameter  int unsigned NUM_REQ = 2,
  localparam int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx
);

  logic [IDX_W-1:0] cand;
  logic             found;

  // Scan candidates starting at the pointer; first hit wins.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    cand  = '0;
    found = 1'b0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      cand = IDX_W'((int'(ptr) + k) % int'(NUM_REQ));
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/reg_native_arbiter.sv
// Shares one downstream reg_native bus among NUM_MST masters: round-robin,
// one transaction in flight, per-master request capture, ack timeout abort.
module reg_native_arbiter
  import reg_native_arb_pkg::*;
#(
  parameter int unsigned NUM_MST     = 2,
  parameter int unsigned ADDR_WIDTH  = 48,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                          reg_native_arbiter_clk,
  input  logic                          reg_native_arbiter_rst,
  input  logic [NUM_MST-1:0]            mst_req_vld,
  input  logic [NUM_MST*ADDR_WIDTH-1:0] mst_addr,
  input  logic [NUM_MST-1:0]            mst_wr_en,
  input  logic [NUM_MST-1:0]            mst_rd_en,
  input  logic [NUM_MST*DATA_WIDTH-1:0] mst_wr_data,
  input  logic [NUM_MST-1:0]            mst_soft_rst,
  output logic [NUM_MST-1:0]            mst_ack_vld,
  output logic [NUM_MST-1:0]            mst_err,
  output logic [NUM_MST*DATA_WIDTH-1:0] mst_rd_data,
  reg_native_arbiter_if.master          ds,
  output logic                          busy,
  output logic                          timeout_evt
);

  localparam int unsigned IDX_W = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;
  localparam int unsigned TMR_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

  state_e                  state_q, state_d;
  logic [NUM_MST-1:0]      pending_q, cap, pend_clr;
  req_t                    req_q [NUM_MST];
  logic [IDX_W-1:0]        rr_q, rr_d, grant_q, grant_d, arb_idx;
  logic [NUM_MST-1:0]      arb_gnt;
  logic [TMR_W-1:0]        timer_q, timer_d;
  logic                    cur_rd_q, cur_rd_d;
  logic                    abort_q, abort_d;

  logic                    ds_req_d, ds_wr_d, ds_rd_d;
  logic [ADDR_WIDTH-1:0]   ds_addr_d;
  logic [DATA_WIDTH-1:0]   ds_wdata_d;
  logic [NUM_MST-1:0]      ack_d, err_d;
  logic [NUM_MST*DATA_WIDTH-1:0] rdata_d;

  rr_arbiter #(.NUM_REQ(NUM_MST)) u_rr (
    .req (pending_q),
    .ptr (rr_q),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  // Accept a request only into an empty slot whose owner is not in flight.
  always_comb begin
    cap = '0;
    for (int i = 0; i < int'(NUM_MST); i++) begin
      cap[i] = mst_req_vld[i] & ~pending_q[i] &
               ~((state_q == WAIT) && (grant_q == IDX_W'(i)));
    end
  end

  // Per-master one-entry request slots.
  always_ff @(posedge reg_native_arbiter_clk) begin
    if (reg_native_arbiter_rst) begin
      pending_q <= '0;
      for (int i = 0; i < int'(NUM_MST); i++) begin
        req_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(NUM_MST); i++) begin
        if (cap[i]) begin
          pending_q[i]     <= 1'b1;
          req_q[i].addr    <= REQ_ADDR_W'(mst_addr[i*ADDR_WIDTH +: ADDR_WIDTH]);
          req_q[i].wr_en   <= mst_wr_en[i];
          req_q[i].rd_en   <= mst_rd_en[i];
          req_q[i].wr_data <= REQ_DATA_W'(mst_wr_data[i*DATA_WIDTH +: DATA_WIDTH]);
        end else if (pend_clr[i]) begin
          pending_q[i] <= 1'b0;
        end
      end
    end
  end

  // Next state, grant, timer and registered-output values.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_d       = rr_q;
    timer_d    = timer_q;
    cur_rd_d   = cur_rd_q;
    abort_d    = 1'b0;
    pend_clr   = '0;
    ds_req_d   = 1'b0;
    ds_addr_d  = '0;
    ds_wr_d    = 1'b0;
    ds_rd_d    = 1'b0;
    ds_wdata_d = '0;
    ack_d      = '0;
    err_d      = '0;
    rdata_d    = '0;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (|pending_q) begin
          state_d    = WAIT;
          grant_d    = arb_idx;
          pend_clr   = arb_gnt;
          rr_d       = (arb_idx == IDX_W'(NUM_MST - 1)) ? '0 : arb_idx + IDX_W'(1);
          cur_rd_d   = req_q[arb_idx].rd_en;
          ds_req_d   = 1'b1;
          ds_addr_d  = ADDR_WIDTH'(req_q[arb_idx].addr);
          ds_wr_d    = req_q[arb_idx].wr_en;
          ds_rd_d    = req_q[arb_idx].rd_en;
          ds_wdata_d = DATA_WIDTH'(req_q[arb_idx].wr_data);
        end
      end
      WAIT: begin
        if (ds.ack_vld) begin
          state_d         = IDLE;
          ack_d[grant_q]  = 1'b1;
          err_d[grant_q]  = ds.err;
          if (cur_rd_q) begin
            rdata_d[grant_q*DATA_WIDTH +: DATA_WIDTH] = ds.rd_data;
          end
        end else if ((TIMEOUT_CYC != 0) && (timer_q == TMR_W'(TIMEOUT_CYC))) begin
          state_d        = IDLE;
          ack_d[grant_q] = 1'b1;
          err_d[grant_q] = 1'b1;
          abort_d        = 1'b1;
        end else if (timer_q < TMR_W'(TIMEOUT_CYC)) begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge reg_native_arbiter_clk) begin
    if (reg_native_arbiter_rst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      rr_q        <= '0;
      timer_q     <= '0;
      cur_rd_q    <= 1'b0;
      abort_q     <= 1'b0;
      ds.req_vld  <= 1'b0;
      ds.addr     <= '0;
      ds.wr_en    <= 1'b0;
      ds.rd_en    <= 1'b0;
      ds.wr_data  <= '0;
      mst_ack_vld <= '0;
      mst_err     <= '0;
      mst_rd_data <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_q        <= rr_d;
      timer_q     <= timer_d;
      cur_rd_q    <= cur_rd_d;
      abort_q     <= abort_d;
      ds.req_vld  <= ds_req_d;
      ds.addr     <= ds_addr_d;
      ds.wr_en    <= ds_wr_d;
      ds.rd_en    <= ds_rd_d;
      ds.wr_data  <= ds_wdata_d;
      mst_ack_vld <= ack_d;
      mst_err     <= err_d;
      mst_rd_data <= rdata_d;
    end
  end

  assign busy        = (state_q == WAIT);
  assign timeout_evt = abort_q;
  assign ds.soft_rst = (|mst_soft_rst) | abort_q;

  // Master protocol checks: no request into a full slot or while in flight.
  for (genvar g = 0; g < int'(NUM_MST); g++) begin : g_chk
    a_no_overrun: assert property (@(posedge reg_native_arbiter_clk)
      disable iff (reg_native_arbiter_rst)
      mst_req_vld[g] |-> (!pending_q[g] && !((state_q == WAIT) && (grant_q == IDX_W'(g)))));
    a_one_type: assert property (@(posedge reg_native_arbiter_clk)
      disable iff (reg_native_arbiter_rst)
      mst_req_vld[g] |-> (mst_wr_en[g] ^ mst_rd_en[g]));
  end

endmodule
